// File: rtl/uart_program_loader.sv
// uart_program_loader
// Receives 8N1 UART bytes and packs them little-endian into 32-bit
// instruction words. Each completed word is handed to instruction memory
// with a one-cycle write strobe. The address then advances by 4.
//
// Parameters
//   CLKS_PER_BIT : clock cycles per UART bit (4..4095)
//   BASE_ADDR    : address of the first word after reset or restart
// Ports
//   clock_reg   in   single clock, rising edge
//   reset       in   asynchronous active-low reset
//   rx          in   UART line, idle high, asynchronous to clock_reg
//   load_en     in   1 = receive; 0 = hold idle and drop any partial word
//   restart     in   synchronous clear of FSM, lane, address and error flag
//   we          out  one-cycle write strobe
//   addr        out  byte address of the word being written
//   wdata       out  assembled word (changes only when a word is written)
//   busy        out  receiving a byte, or a partial word is held
//   framing_err out  sticky; set when a stop bit is sampled low
module uart_program_loader #(
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter logic [7:0]  BASE_ADDR    = 8'h00
) (
  input  logic        clock_reg,
  input  logic        reset,
  input  logic        rx,
  input  logic        load_en,
  input  logic        restart,
  output logic        we,
  output logic [7:0]  addr,
  output logic [31:0] wdata,
  output logic        busy,
  output logic        framing_err
);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

  localparam logic [11:0] BIT_LAST  = 12'(CLKS_PER_BIT - 1);
  localparam logic [11:0] HALF_LAST = 12'(CLKS_PER_BIT / 2 - 1);

  logic        rx_meta_q, rx_meta_d;
  logic        rx_sync_q, rx_sync_d;
  logic [1:0]  fill_q, fill_d;    // synchronizer holds real samples
  logic        armed_q, armed_d;  // rx has been seen high since reset
  state_e      state_q, state_d;
  logic [11:0] cnt_q, cnt_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  shift_q, shift_d;
  logic [1:0]  lane_q, lane_d;
  logic [31:0] word_q, word_d;    // assembly buffer; keeps bytes not yet refilled
  logic [31:0] wdata_q, wdata_d;
  logic [7:0]  addr_q, addr_d;
  logic        we_q, we_d;
  logic        busy_q, busy_d;
  logic        ferr_q, ferr_d;

  always_comb begin
    // NOTE: every signal gets a default first. This keeps the block
    // purely combinational, so no latches are inferred.
    rx_meta_d = rx;
    rx_sync_d = rx_meta_q;
    fill_d    = {fill_q[0], 1'b1};
    armed_d   = armed_q | (fill_q[1] & rx_sync_q);
    state_d   = state_q;
    cnt_d     = cnt_q + 12'd1;
    bit_d     = bit_q;
    shift_d   = shift_q;
    lane_d    = lane_q;
    word_d    = word_q;
    wdata_d   = wdata_q;
    addr_d    = we_q ? addr_q + 8'd4 : addr_q;
    we_d      = 1'b0;
    ferr_d    = ferr_q;

    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (load_en && armed_q && !rx_sync_q) state_d = START;
      end
      START: begin
        // Recheck the line at mid start bit. A short low pulse is
        // rejected here as a glitch.
        if (cnt_q == HALF_LAST) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = rx_sync_q ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d   = '0;
          shift_d = {rx_sync_q, shift_q[7:1]};  // LSB arrives first
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = STOP;
        end
      end
      STOP: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d   = '0;
          state_d = IDLE;
          if (rx_sync_q) begin
            word_d[8*lane_q +: 8] = shift_q;
            lane_d = lane_q + 2'd1;
            if (lane_q == 2'd3) begin
              wdata_d = {shift_q, word_q[23:0]};
              we_d    = 1'b1;
            end
          end else begin
            ferr_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (!load_en) begin
      state_d = IDLE;
      cnt_d   = '0;
      lane_d  = '0;
      we_d    = 1'b0;
      wdata_d = wdata_q;
    end

    if (restart) begin
      state_d = IDLE;
      cnt_d   = '0;
      lane_d  = '0;
      addr_d  = BASE_ADDR;
      ferr_d  = 1'b0;
      we_d    = 1'b0;
      wdata_d = wdata_q;
    end

    busy_d = (state_d != IDLE) || (lane_d != 2'd0);
  end

  // NOTE: sequential state uses non-blocking assignments only. All flops
  // then update together and simulation matches hardware.
  always_ff @(posedge clock_reg or negedge reset) begin
    if (!reset) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      fill_q    <= '0;
      armed_q   <= 1'b0;
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      lane_q    <= '0;
      word_q    <= '0;
      wdata_q   <= '0;
      addr_q    <= BASE_ADDR;
      we_q      <= 1'b0;
      busy_q    <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      rx_meta_q <= rx_meta_d;
      rx_sync_q <= rx_sync_d;
      fill_q    <= fill_d;
      armed_q   <= armed_d;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      lane_q    <= lane_d;
      word_q    <= word_d;
      wdata_q   <= wdata_d;
      addr_q    <= addr_d;
      we_q      <= we_d;
      busy_q    <= busy_d;
      ferr_q    <= ferr_d;
    end
  end

  assign we          = we_q;
  assign addr        = addr_q;
  assign wdata       = wdata_q;
  assign busy        = busy_q;
  assign framing_err = ferr_q;

endmodule

// File: tb/tb_uart_program_loader.sv
// tb_uart_program_loader
// Directed sequence with random payload bytes for uart_program_loader
// (CLKS_PER_BIT = 4, BASE_ADDR = 0). A reference model of lanes, words and
// addresses predicts every write. A negedge monitor records the writes
// the DUT actually performs.
module tb_uart_program_loader;

  localparam int CPB = 4;

  logic        clock_reg = 1'b0;
  logic        reset     = 1'b0;
  logic        rx        = 1'b1;
  logic        load_en   = 1'b1;
  logic        restart   = 1'b0;
  logic        we;
  logic [7:0]  addr;
  logic [31:0] wdata;
  logic        busy;
  logic        framing_err;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state
  logic [7:0]  m_word [4];
  logic [1:0]  m_lane;
  logic [7:0]  m_addr;
  logic        m_ferr;
  logic [39:0] exp_q [$];
  logic [39:0] obs_q [$];

  uart_program_loader #(.CLKS_PER_BIT(CPB), .BASE_ADDR(8'h00)) dut (
    .clock_reg   (clock_reg),
    .reset       (reset),
    .rx          (rx),
    .load_en     (load_en),
    .restart     (restart),
    .we          (we),
    .addr        (addr),
    .wdata       (wdata),
    .busy        (busy),
    .framing_err (framing_err)
  );

  always #5 clock_reg = ~clock_reg;

  // A strobe held high for two cycles shows up as two entries.
  always @(negedge clock_reg) if (we) obs_q.push_back({addr, wdata});

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not reach its summary");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear(input bit full);
    if (full) begin
      foreach (m_word[i]) m_word[i] = 8'h00;
    end
    m_lane = 2'd0;
    m_addr = 8'h00;
    m_ferr = 1'b0;
  endtask

  task automatic model_byte(input logic [7:0] b, input bit ok);
    if (!ok) begin
      m_ferr = 1'b1;
      return;
    end
    m_word[m_lane] = b;
    if (m_lane == 2'd3) begin
      exp_q.push_back({m_addr, m_word[3], m_word[2], m_word[1], m_word[0]});
      m_addr = m_addr + 8'd4;
    end
    m_lane = m_lane + 2'd1;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clock_reg);
    #1;
  endtask

  task automatic hold(input logic v, input int n);
    rx = v;
    cycles(n);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit stop_ok);
    hold(1'b0, CPB);
    for (int i = 0; i < 8; i++) hold(b[i], CPB);
    hold(stop_ok, CPB);
    model_byte(b, stop_ok);
  endtask

  task automatic send_random(input int n);
    for (int i = 0; i < n; i++) send_byte(8'($urandom), 1'b1);
  endtask

  task automatic check_writes(input string tag);
    int n;
    hold(1'b1, 8);
    check({tag, "_we_count"}, 64'(obs_q.size()), 64'(exp_q.size()));
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++)
      check($sformatf("%s_write%0d", tag, i), 64'(obs_q[i]), 64'(exp_q[i]));
    check({tag, "_addr"}, 64'(addr), 64'(m_addr));
    obs_q.delete();
    exp_q.delete();
  endtask

  initial begin
    logic [7:0] first_word [4];
    logic [7:0] b;
    first_word = '{8'h13, 8'h05, 8'h50, 8'h00};
    model_clear(1'b1);

    // Reset state, with rx low so release must not fake a start bit
    rx = 1'b0;
    cycles(3);
    check("rst_we", 64'(we), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_ferr", 64'(framing_err), 64'(0));
    check("rst_addr", 64'(addr), 64'(0));
    check("rst_wdata", 64'(wdata), 64'(0));
    reset = 1'b1;
    cycles(10);
    check("release_rx_low_busy", 64'(busy), 64'(0));
    hold(1'b1, 6);

    // Known word, then a random word at the next address
    foreach (first_word[i]) send_byte(first_word[i], 1'b1);
    check_writes("known_word");
    check("known_wdata", 64'(wdata), 64'(32'h00500513));
    send_random(2);
    check("wdata_stable_mid_word", 64'(wdata), 64'(32'h00500513));
    check("busy_partial_word", 64'(busy), 64'(1));
    send_random(2);
    check_writes("second_word");

    // One-cycle glitch is rejected
    hold(1'b0, 1);
    hold(1'b1, 5);
    check("glitch_busy", 64'(busy), 64'(0));

    // Bad stop bit at lane 0, then at lane 1; lane must not move
    send_byte(8'hAA, 1'b0);
    hold(1'b1, 12);
    check("ferr_set", 64'(framing_err), 64'(m_ferr));
    send_random(4);
    check_writes("after_ferr");
    send_random(1);
    send_byte(8'($urandom), 1'b0);
    hold(1'b1, 12);
    send_random(3);
    check_writes("ferr_mid_word");
    check("ferr_sticky", 64'(framing_err), 64'(1));

    // Restart mid-word clears lane, address and the error flag
    send_random(2);
    restart = 1'b1;
    cycles(1);
    restart = 1'b0;
    model_clear(1'b0);
    cycles(2);
    check("restart_ferr", 64'(framing_err), 64'(0));
    check("restart_addr", 64'(addr), 64'(0));
    check("restart_busy", 64'(busy), 64'(0));
    send_random(4);
    check_writes("after_restart");

    // Dropping load_en discards the partial word but keeps the address
    send_random(2);
    load_en = 1'b0;
    cycles(1);
    load_en = 1'b1;
    m_lane = 2'd0;
    cycles(3);
    check("load_en_drop_busy", 64'(busy), 64'(0));
    send_random(4);
    check_writes("after_load_en_drop");

    // Reset during the data bits of the lane-2 byte
    send_random(2);
    b = 8'($urandom);
    hold(1'b0, CPB);
    hold(b[0], CPB);
    hold(b[1], CPB);
    reset = 1'b0;
    rx = 1'b1;
    cycles(3);
    check("mid_reset_wdata", 64'(wdata), 64'(0));
    check("mid_reset_busy", 64'(busy), 64'(0));
    reset = 1'b1;
    model_clear(1'b1);
    hold(1'b1, 6);
    send_random(4);
    check_writes("after_mid_reset");

    // 65 words: wrap from 0xFC to 0x00
    restart = 1'b1;
    cycles(1);
    restart = 1'b0;
    model_clear(1'b0);
    cycles(2);
    send_random(65 * 4);
    check("wrap_word64_addr", 64'(exp_q[63][39:32]), 64'(8'hFC));
    check_writes("wrap");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/uart_program_loader.md
UART_PROGRAM_LOADER -- requirements
Module: uart_program_loader

Interface
REQ-001 SHALL provide parameter CLKS_PER_BIT, default 434, clock cycles per UART bit (50 MHz / 115200), legal range 4..4095.
REQ-002 SHALL provide parameter BASE_ADDR, default 8'h00, first instruction byte address written after reset/restart.
REQ-003 clock_reg  input  1  single clock, all state on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 rx  input  1  UART serial line (8N1, idle high, LSB first), asynchronous to clock_reg.
REQ-006 load_en  input  1  high = receive and assemble; low = block held idle.
REQ-007 restart  input  1  synchronous clear of address, lane and error state.
REQ-008 we  output  1  one-cycle write strobe to instruction memory.
REQ-009 addr  output  8  byte address of the word being written (word-aligned).
REQ-010 wdata  output  32  assembled instruction word.
REQ-011 busy  output  1  high while FSM not IDLE or a partial word is held.
REQ-012 framing_err  output  1  sticky flag, stop bit sampled low.

Function
REQ-013 rx SHALL pass through a 2-flop synchronizer; all FSM decisions use the synchronized value only.
REQ-014 FSM states SHALL be IDLE, START, DATA, STOP; only IDLE -> START on synchronized rx = 0 with load_en = 1.
REQ-015 START: wait CLKS_PER_BIT/2 cycles, resample; rx = 0 -> DATA, rx = 1 -> IDLE (glitch rejected, nothing stored).
REQ-016 DATA: sample every CLKS_PER_BIT cycles, 8 samples, shift LSB first into byte register, then -> STOP.
REQ-017 STOP: wait CLKS_PER_BIT cycles, sample; rx = 1 -> byte accepted; rx = 0 -> byte discarded, framing_err set, lane unchanged; both -> IDLE.
REQ-018 Accepted byte SHALL be placed in wdata[8*lane+7 : 8*lane] (little-endian), lane (2-bit) then increments.
REQ-019 When the accepted byte is lane 3, we SHALL be 1 for exactly the next cycle with addr and the complete wdata valid in that cycle.
REQ-020 addr SHALL increment by 4 (mod 256) on the cycle after the we pulse; 8'hFC wraps to 8'h00.
REQ-021 addr and wdata SHALL hold stable between writes; wdata lanes not yet refilled retain previous bytes.
REQ-022 load_en low SHALL force IDLE at the next edge and clear lane to 0 (partial word dropped, no we); addr and framing_err retained.
REQ-023 restart SHALL have priority over all events: FSM IDLE, lane 0, addr BASE_ADDR, framing_err 0, we 0 on the next edge.
REQ-024 busy SHALL equal (state != IDLE) OR (lane != 0), registered.
REQ-025 Bit timing counter SHALL restart at every state change; no accumulated drift across bytes.
REQ-026 A new start bit SHALL be accepted in the first IDLE cycle after STOP (back-to-back bytes, zero idle bits).

Reset
REQ-027 While reset = 0: state IDLE, synchronizer flops 1, lane 0, addr BASE_ADDR, wdata 0, we 0, busy 0, framing_err 0.
REQ-028 reset asserted mid-byte or mid-word SHALL discard all partial data; first byte after release is lane 0.
REQ-029 Release of reset SHALL not create a start condition even if rx is low at release until rx has been seen high for one synchronized sample.

Verification (CLKS_PER_BIT = 4, BASE_ADDR = 0)
REQ-030 Send 0x13,0x05,0x50,0x00 back-to-back -> single we pulse, addr 0x00, wdata 32'h00500513; next 4 bytes -> we at addr 0x04.
REQ-031 rx low for 1 cycle only -> no byte stored, lane stays 0, busy returns 0 within 4 cycles.
REQ-032 Byte 0xAA with stop bit 0 -> framing_err = 1, lane unchanged; following 4 valid bytes still produce one correct word.
REQ-033 Send 65 words -> 64th written at 0xFC, 65th written at 0x00, we count = 65.
REQ-034 Two bytes sent then load_en pulsed low -> no we, busy 0; next 4 bytes form a word at the unchanged addr.
REQ-035 reset asserted during DATA of lane-2 byte, then full word sent -> we at addr 0x00 with only new bytes in wdata.
